// File: rtl/stage_param_loader.sv
// stage_param_loader
//   Pulls one stage worth of classifier parameters out of the stage database
//   and hands them to the classifier evaluator one complete record at a time.
//   A start pulse fetches NUM_PARAM_PER_CLASSIFIER words per classifier,
//   presents the assembled record on a valid/ready handshake, and repeats
//   for every classifier of the stage. A one-cycle done pulse ends the stage.
//
// Ports
//   clk_fpga, reset_fpga  clock, async active-high reset
//   i_start               load request, sampled only while idle
//   o_ren, i_data         database read enable / returned word (RD_LATENCY later)
//   o_record              flattened record, parameter p at [16p+15:16p]
//   o_classifier_index    index of the record on o_record
//   o_record_valid        record complete and held stable
//   i_record_ready        downstream accepts the record
//   o_busy                high whenever not idle
//   o_stage_done          one-cycle pulse after the final record is accepted
module stage_param_loader #(
  parameter int DATA_WIDTH_16            = 16,
  parameter int NUM_CLASSIFIERS_STAGE    = 10,
  parameter int NUM_PARAM_PER_CLASSIFIER = 18,
  parameter int RD_LATENCY               = 1
) (
  input  logic                                              clk_fpga,
  input  logic                                              reset_fpga,
  input  logic                                              i_start,
  output logic                                              o_ren,
  input  logic [DATA_WIDTH_16-1:0]                          i_data,
  output logic [DATA_WIDTH_16*NUM_PARAM_PER_CLASSIFIER-1:0] o_record,
  output logic [7:0]                                        o_classifier_index,
  output logic                                              o_record_valid,
  input  logic                                              i_record_ready,
  output logic                                              o_busy,
  output logic                                              o_stage_done
);

  localparam int CW = $clog2(NUM_PARAM_PER_CLASSIFIER + 1);
  localparam logic [CW-1:0] NUM_WORDS = CW'(NUM_PARAM_PER_CLASSIFIER);
  localparam logic [CW-1:0] LAST_SLOT = CW'(NUM_PARAM_PER_CLASSIFIER - 1);
  localparam logic [7:0]    LAST_CLS  = 8'(NUM_CLASSIFIERS_STAGE - 1);

  typedef enum logic [1:0] {IDLE, FETCH, PRESENT, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] issue_cnt, recv_cnt;
  // vld_pipe[n] is high n cycles after a read was issued; the top tap
  // lines up with the returned word on i_data.
  logic [RD_LATENCY:1] vld_pipe;
  logic tap, cap_last, accept, last_cls;
  logic [NUM_PARAM_PER_CLASSIFIER-1:0][DATA_WIDTH_16-1:0] rec;

  // Captures only count in FETCH; exactly one record's worth of reads is
  // ever issued, so the pipe is empty whenever the state leaves FETCH.
  assign tap      = vld_pipe[RD_LATENCY] && (state == FETCH);
  assign cap_last = tap && (recv_cnt == LAST_SLOT);
  assign accept   = (state == PRESENT) && i_record_ready;
  assign last_cls = (o_classifier_index == LAST_CLS);
  assign o_record = rec;

  // state register
  always_ff @(posedge clk_fpga or posedge reset_fpga) begin
    if (reset_fpga) state <= IDLE;
    else            state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start)  state_nxt = FETCH;
      FETCH:   if (cap_last) state_nxt = PRESENT;
      PRESENT: if (accept)   state_nxt = last_cls ? DONE : FETCH;
      DONE:                  state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // outputs
  always_comb begin
    o_ren          = 1'b0;
    o_record_valid = 1'b0;
    o_stage_done   = 1'b0;
    o_busy         = (state != IDLE);
    case (state)
      FETCH:   o_ren          = (issue_cnt < NUM_WORDS);
      PRESENT: o_record_valid = 1'b1;
      DONE:    o_stage_done   = 1'b1;
      default: ;
    endcase
  end

  // read-valid tracking
  always_ff @(posedge clk_fpga or posedge reset_fpga) begin
    if (reset_fpga) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= o_ren;
      for (int i = 2; i <= RD_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  // issue / receive counters and classifier index
  always_ff @(posedge clk_fpga or posedge reset_fpga) begin
    if (reset_fpga) begin
      issue_cnt          <= '0;
      recv_cnt           <= '0;
      o_classifier_index <= '0;
    end else begin
      case (state)
        IDLE: begin
          issue_cnt          <= '0;
          recv_cnt           <= '0;
          o_classifier_index <= '0;
        end
        FETCH: begin
          if (o_ren) issue_cnt <= issue_cnt + CW'(1);
          if (tap)   recv_cnt  <= recv_cnt + CW'(1);
        end
        PRESENT: if (accept && !last_cls) begin
          issue_cnt          <= '0;
          recv_cnt           <= '0;
          o_classifier_index <= o_classifier_index + 8'd1;
        end
        default: ;
      endcase
    end
  end

  // record slots; every slot is rewritten for each classifier before the
  // record is presented, so no explicit clear between classifiers is needed
  always_ff @(posedge clk_fpga or posedge reset_fpga) begin
    if (reset_fpga) begin
      rec <= '0;
    end else if (tap) begin
      for (int p = 0; p < NUM_PARAM_PER_CLASSIFIER; p++)
        if (recv_cnt == CW'(p)) rec[p] <= i_data;
    end
  end

endmodule

// File: tb/tb_stage_param_loader.sv
// Directed bench for stage_param_loader: two instances (read latency 1 and 3)
// each fed by a ROM model returning word = address. Expected records are
// queued at start and compared when the DUT presents them.
module tb_stage_param_loader;
  localparam int DW = 16, NC = 2, NP = 18, RECW = DW * NP;
  localparam logic [15:0] AMAX = 16'(NC * NP - 1);

  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;

  logic start1 = 1'b0, ready1 = 1'b0, ren1, v1, busy1, done1;
  logic start3 = 1'b0, ready3 = 1'b0, ren3, v3, busy3, done3;
  logic [DW-1:0]   d1, d3;
  logic [RECW-1:0] r1, r3;
  logic [7:0]      idx1, idx3;

  stage_param_loader #(.DATA_WIDTH_16(DW), .NUM_CLASSIFIERS_STAGE(NC),
    .NUM_PARAM_PER_CLASSIFIER(NP), .RD_LATENCY(1)) u1 (
    .clk_fpga(clk), .reset_fpga(rst), .i_start(start1), .o_ren(ren1),
    .i_data(d1), .o_record(r1), .o_classifier_index(idx1),
    .o_record_valid(v1), .i_record_ready(ready1), .o_busy(busy1),
    .o_stage_done(done1));

  stage_param_loader #(.DATA_WIDTH_16(DW), .NUM_CLASSIFIERS_STAGE(NC),
    .NUM_PARAM_PER_CLASSIFIER(NP), .RD_LATENCY(3)) u3 (
    .clk_fpga(clk), .reset_fpga(rst), .i_start(start3), .o_ren(ren3),
    .i_data(d3), .o_record(r3), .o_classifier_index(idx3),
    .o_record_valid(v3), .i_record_ready(ready3), .o_busy(busy3),
    .o_stage_done(done3));

  // ROM models: address wraps at database depth; data pipes are not reset so
  // stale words stay on i_data after a reset.
  logic [15:0] a1, a3, q1;
  logic [2:0][15:0] q3;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin a1 <= '0; a3 <= '0; end
    else begin
      if (ren1) a1 <= (a1 == AMAX) ? 16'd0 : a1 + 16'd1;
      if (ren3) a3 <= (a3 == AMAX) ? 16'd0 : a3 + 16'd1;
    end
  end
  always_ff @(posedge clk) begin
    q1 <= a1;
    q3 <= {q3[1], q3[0], a3};
  end
  assign d1 = q1;
  assign d3 = q3[2];

  int nren1 = 0, nren3 = 0;
  always @(posedge clk) begin
    if (ren1 === 1'b1) nren1 <= nren1 + 1;
    if (ren3 === 1'b1) nren3 <= nren3 + 1;
  end

  typedef struct { logic [7:0] idx; logic [RECW-1:0] rec; } exp_t;
  exp_t sb1[$], sb3[$];
  exp_t last_exp;
  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input int i);
    exp_t e;
    e.idx = 8'(i);
    for (int p = 0; p < NP; p++) e.rec[p*DW +: DW] = 16'(i * NP + p);
    return e;
  endfunction

  function automatic logic vsel(input int sel);
    return (sel == 3) ? v3 : v1;
  endfunction

  // caller is at a negedge; returns one negedge later with start low again
  task automatic start_stage(input int sel);
    for (int i = 0; i < NC; i++) if (sel == 3) sb3.push_back(mk(i)); else sb1.push_back(mk(i));
    if (sel == 3) start3 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start3 = 1'b0;
  endtask

  task automatic wait_valid(input int sel, input int budget, output int w);
    w = 0;
    while (!vsel(sel) && w < budget) begin @(negedge clk); w++; end
    if (!vsel(sel)) begin
      n_tests++; n_fail++;
      $display("FAIL wait_valid dut%0d: no record after %0d cycles", sel, budget);
    end
  endtask

  task automatic pop_cmp(input int sel, input string tag);
    exp_t e;
    if ((sel == 3 && sb3.size() == 0) || (sel != 3 && sb1.size() == 0)) begin
      n_tests++; n_fail++;
      $display("FAIL %s: record presented with empty scoreboard", tag);
    end else begin
      e = (sel == 3) ? sb3.pop_front() : sb1.pop_front();
      last_exp = e;
      chk({tag, " idx"}, (sel == 3) ? idx3 : idx1, e.idx);
      chk({tag, " rec"}, (sel == 3) ? r3 : r1, e.rec);
    end
  endtask

  int w, n0;

  initial begin
    // 1. async reset mid-cycle, then idle with no start
    #3 rst = 1'b1;
    #1;
    chk("reset u1", {ren1, v1, busy1, done1, idx1, r1}, '0);
    chk("reset u3", {ren3, v3, busy3, done3, idx3, r3}, '0);
    @(negedge clk); rst = 1'b0;
    n0 = nren1;
    repeat (20) @(negedge clk);
    chk("idle no ren", nren1 - n0, 0);
    chk("idle busy", busy1, 1'b0);

    // 2. nominal load, ready tied high
    ready1 = 1'b1; n0 = nren1;
    start_stage(1);
    wait_valid(1, 40, w);
    chk("nom lat0", w, 19);
    pop_cmp(1, "nom r0");
    @(negedge clk);
    wait_valid(1, 40, w);
    chk("nom lat1", w, 19);
    pop_cmp(1, "nom r1");
    @(negedge clk);
    chk("nom done", {done1, busy1}, 2'b11);
    @(negedge clk);
    chk("nom idle", {done1, busy1}, 2'b00);
    chk("nom reads", nren1 - n0, NC * NP);

    // 3. backpressure for 5 cycles
    ready1 = 1'b0; n0 = nren1;
    start_stage(1);
    wait_valid(1, 40, w);
    chk("bp lat", w, 19);
    pop_cmp(1, "bp r0");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp hold", {v1, ren1, idx1}, {2'b10, 8'd0});
      chk("bp rec", r1, last_exp.rec);
    end
    ready1 = 1'b1;
    @(negedge clk);
    chk("bp resume", {ren1, v1}, 2'b10);
    wait_valid(1, 40, w);
    chk("bp lat1", w, 19);
    pop_cmp(1, "bp r1");
    @(negedge clk);
    chk("bp done", done1, 1'b1);
    @(negedge clk);
    chk("bp reads", nren1 - n0, NC * NP);

    // 4. start pulses in FETCH, PRESENT and DONE are ignored
    n0 = nren1;
    start_stage(1);
    repeat (4) @(negedge clk);
    start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    wait_valid(1, 40, w);
    chk("sb lat0", w, 14);
    start1 = 1'b1;
    pop_cmp(1, "sb r0");
    @(negedge clk); start1 = 1'b0;
    wait_valid(1, 40, w);
    chk("sb lat1", w, 19);
    pop_cmp(1, "sb r1");
    @(negedge clk);
    chk("sb done", done1, 1'b1);
    start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    chk("sb idle", {busy1, done1}, 2'b00);
    repeat (3) @(negedge clk);
    chk("sb no restart", busy1, 1'b0);
    chk("sb reads", nren1 - n0, NC * NP);
    chk("sb drained", sb1.size(), 0);

    // 5. reset mid-FETCH of classifier 1 with a read in flight
    start_stage(1);
    wait_valid(1, 40, w);
    pop_cmp(1, "rf r0");
    repeat (11) @(negedge clk);
    chk("rf fetching", {ren1, idx1}, {1'b1, 8'd1});
    rst = 1'b1;
    #1;
    chk("rf reset", {ren1, v1, busy1, done1, idx1, r1}, '0);
    sb1.delete();
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    n0 = nren1;
    start_stage(1);
    wait_valid(1, 40, w);
    chk("rf lat0", w, 19);
    pop_cmp(1, "rf new r0");
    @(negedge clk);
    wait_valid(1, 40, w);
    pop_cmp(1, "rf new r1");
    @(negedge clk);
    chk("rf done", done1, 1'b1);
    chk("rf reads", nren1 - n0, NC * NP);

    // 6. read latency 3
    ready3 = 1'b1; n0 = nren3;
    start_stage(3);
    wait_valid(3, 40, w);
    chk("l3 lat0", w, 21);
    chk("l3 reads0", {nren3 - n0, 31'(ren3)}, {NP, 31'd0});
    pop_cmp(3, "l3 r0");
    @(negedge clk);
    wait_valid(3, 40, w);
    chk("l3 lat1", w, 21);
    pop_cmp(3, "l3 r1");
    @(negedge clk);
    chk("l3 done", done3, 1'b1);
    @(negedge clk);
    chk("l3 idle", busy3, 1'b0);
    chk("l3 reads", nren3 - n0, NC * NP);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
